// File: rtl/dm9000a_reg_seq_pkg.sv
// Shared definitions for the DM9000A register access sequencer:
// FSM state encoding and default strobe/recovery timing.
package dm9000a_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      IDX_STB = 3'd1,
      IDX_GAP = 3'd2,
      DAT_STB = 3'd3,
      DAT_GAP = 3'd4,
      RSP     = 3'd5
   } state_t;

   localparam int CNT_W         = 4;
   localparam int PULSE_CYC_DEF = 2;
   localparam int GAP_CYC_DEF   = 1;

endpackage

// File: rtl/dm9000a_reg_seq_if.sv
// Request/response handshake plus DM9000A bus pins, grouped for the sequencer.
// The sequencer takes the slave side; the host and the chip model take the master side.
interface dm9000a_reg_seq_if;

   logic        req_valid;
   logic        req_ready;
   logic        req_write;
   logic        req_noidx;
   logic [7:0]  req_addr;
   logic [15:0] req_wdata;
   logic        rsp_valid;
   logic [15:0] rsp_rdata;
   logic        bus_cmd;
   logic        bus_cs_n;
   logic        bus_rd_n;
   logic        bus_wr_n;
   logic [15:0] bus_wdata;
   logic [15:0] bus_rdata;

   modport master (
      output req_valid, req_write, req_noidx, req_addr, req_wdata, bus_rdata,
      input  req_ready, rsp_valid, rsp_rdata,
      input  bus_cmd, bus_cs_n, bus_rd_n, bus_wr_n, bus_wdata
   );

   modport slave (
      input  req_valid, req_write, req_noidx, req_addr, req_wdata, bus_rdata,
      output req_ready, rsp_valid, rsp_rdata,
      output bus_cmd, bus_cs_n, bus_rd_n, bus_wr_n, bus_wdata
   );

endinterface

// File: rtl/dm9000a_reg_seq.sv
// DM9000A register access sequencer: optional index cycle then one data cycle,
// every strobe and recovery phase timed by a single down-counter.
module dm9000a_reg_seq
   import dm9000a_pkg::*;
#(
   parameter int PULSE_CYC = PULSE_CYC_DEF,
   parameter int GAP_CYC   = GAP_CYC_DEF
) (
   input  logic             iCLK,
   input  logic             iRST_N,
   dm9000a_reg_seq_if.slave io
);

   localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_CYC);
   localparam logic [CNT_W-1:0] GAP_LD   = CNT_W'(GAP_CYC);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               wr_q, wr_d;
   logic [7:0]         addr_q, addr_d;
   logic [15:0]        wdata_q, wdata_d;

   logic               ready_q, ready_d;
   logic               rsp_valid_q, rsp_valid_d;
   logic [15:0]        rdata_q, rdata_d;
   logic               cs_n_q, cs_n_d;
   logic               rd_n_q, rd_n_d;
   logic               wr_n_q, wr_n_d;
   logic               cmd_q, cmd_d;
   logic [15:0]        bwdata_q, bwdata_d;

   always_ff @(posedge iCLK or negedge iRST_N) begin
      if (!iRST_N) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         wr_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
         rdata_q     <= '0;
         cs_n_q      <= 1'b1;
         rd_n_q      <= 1'b1;
         wr_n_q      <= 1'b1;
         cmd_q       <= 1'b0;
         bwdata_q    <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         wr_q        <= wr_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         ready_q     <= ready_d;
         rsp_valid_q <= rsp_valid_d;
         rdata_q     <= rdata_d;
         cs_n_q      <= cs_n_d;
         rd_n_q      <= rd_n_d;
         wr_n_q      <= wr_n_d;
         cmd_q       <= cmd_d;
         bwdata_q    <= bwdata_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      wr_d     = wr_q;
      addr_d   = addr_q;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (io.req_valid) begin
               wr_d    = io.req_write;
               addr_d  = io.req_addr;
               wdata_d = io.req_wdata;
               cnt_d   = PULSE_LD;
               state_d = io.req_noidx ? DAT_STB : IDX_STB;
            end
         end
         IDX_STB: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = IDX_GAP;
               cnt_d   = GAP_LD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         IDX_GAP: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = DAT_STB;
               cnt_d   = PULSE_LD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DAT_STB: begin
            // Read data is sampled on the edge that closes the last strobe cycle.
            if (cnt_q == CNT_W'(1)) begin
               state_d = DAT_GAP;
               cnt_d   = GAP_LD;
               if (!wr_q) rdata_d = io.bus_rdata;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         DAT_GAP: begin
            if (cnt_q == CNT_W'(1)) begin
               state_d = RSP;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RSP: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase

      // Outputs are registered, so they are decoded from the state being entered.
      ready_d     = (state_d == IDLE);
      rsp_valid_d = (state_d == RSP);
      cs_n_d      = !((state_d == IDX_STB) || (state_d == DAT_STB));
      wr_n_d      = !((state_d == IDX_STB) || ((state_d == DAT_STB) && wr_d));
      rd_n_d      = !((state_d == DAT_STB) && !wr_d);
      cmd_d       = cmd_q;
      bwdata_d    = bwdata_q;
      if (state_d == IDX_STB) begin
         cmd_d    = 1'b0;
         bwdata_d = {8'h00, addr_d};
      end else if (state_d == DAT_STB) begin
         cmd_d = 1'b1;
         if (wr_d) bwdata_d = wdata_d;
      end
   end

   assign io.req_ready = ready_q;
   assign io.rsp_valid = rsp_valid_q;
   assign io.rsp_rdata = rdata_q;
   assign io.bus_cs_n  = cs_n_q;
   assign io.bus_rd_n  = rd_n_q;
   assign io.bus_wr_n  = wr_n_q;
   assign io.bus_cmd   = cmd_q;
   assign io.bus_wdata = bwdata_q;

endmodule
